block_dispatcher: RTL and testbench

Top-level dispatcher for the matrix-multiply coprocessor. It walks the output block grid C_ij in row-major order and hands each (i, j) index pair to an idle worker control unit over the Indexes_Ready / Indexes_Received handshake. It tracks which workers are busy through their Result_Ready returns and raises a done pulse once every block has been issued and completed. It sits directly upstream of the worker CUs and feeds their i_Row_Index, i_Column_Index and i_Indexes_Ready inputs.

---
 rtl/coproc_pkg.sv | 25 ++
 rtl/idle_cu_picker.sv | 21 ++
 rtl/block_dispatcher.sv | 121 ++++++++++++
 tb/tb_block_dispatcher.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coproc_pkg.sv
// Shared definitions for the matrix-multiply coprocessor: dispatcher state encoding,
// default geometry and the CU-id width helper used by the worker CU and arbiter.
package coproc_pkg;

  localparam int DEFAULT_NUM_CU      = 4;
  localparam int DEFAULT_INDEX_WIDTH = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_ISSUE  = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Width of a binary CU id; a single CU still needs one bit.
  function automatic int cu_id_width(input int num_cu);
    if (num_cu > 1) begin
      return $clog2(num_cu);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/idle_cu_picker.sv
// Combinational lowest-index picker over the idle workers: one-hot grant plus valid.
module idle_cu_picker
  import coproc_pkg::*;
#(
  parameter int NUM_CU = DEFAULT_NUM_CU
) (
  input  logic [NUM_CU-1:0] busy,
  output logic [NUM_CU-1:0] grant,
  output logic              valid
);

  logic [NUM_CU-1:0] idle_s;

  // Isolating the lowest set bit of the idle vector gives the lowest free CU.
  always_comb begin
    idle_s = ~busy;
    grant  = idle_s & (~idle_s + NUM_CU'(1));
    valid  = |idle_s;
  end

endmodule

// File: rtl/block_dispatcher.sv
// Walks the C_ij output block grid in row-major order and offers each index pair
// to the lowest idle worker CU, then pulses o_Done once every block has returned.
module block_dispatcher
  import coproc_pkg::*;
#(
  parameter int NUM_CU      = DEFAULT_NUM_CU,
  parameter int index_width = DEFAULT_INDEX_WIDTH
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset_n,
  input  logic                   i_Start,
  input  logic [index_width-1:0] i_Block_Count,
  input  logic [NUM_CU-1:0]      i_Indexes_Received,
  input  logic [NUM_CU-1:0]      i_Result_Ready,
  output logic [index_width-1:0] o_Row_Index,
  output logic [index_width-1:0] o_Column_Index,
  output logic [NUM_CU-1:0]      o_Indexes_Ready,
  output logic                   o_Busy,
  output logic                   o_Done
);

  state_t                 state_r;
  logic [index_width-1:0] last_r;
  logic [NUM_CU-1:0]      busy_r;
  logic [NUM_CU-1:0]      grant_s;
  logic                   pick_valid_s;
  logic                   offer_ack_s;
  logic                   last_col_s;
  logic                   last_pair_s;

  idle_cu_picker #(
    .NUM_CU(NUM_CU)
  ) u_picker (
    .busy  (busy_r),
    .grant (grant_s),
    .valid (pick_valid_s)
  );

  // Only the selected CU's acknowledge retires an offer; last_r holds M-1.
  always_comb begin
    offer_ack_s = |(o_Indexes_Ready & i_Indexes_Received);
    last_col_s  = (o_Column_Index == last_r);
    last_pair_s = last_col_s && (o_Row_Index == last_r);
  end

  // Busy mask: results clear bits in any state, an acknowledged offer sets its bit and wins.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      busy_r <= {NUM_CU{1'b0}};
    end else if ((state_r == S_ISSUE) && offer_ack_s) begin
      busy_r <= (busy_r & ~i_Result_Ready) | o_Indexes_Ready;
    end else begin
      busy_r <= busy_r & ~i_Result_Ready;
    end
  end

  // Dispatch FSM with registered index bus, offer, busy and done outputs.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_r         <= S_IDLE;
      last_r          <= {index_width{1'b0}};
      o_Row_Index     <= {index_width{1'b0}};
      o_Column_Index  <= {index_width{1'b0}};
      o_Indexes_Ready <= {NUM_CU{1'b0}};
      o_Busy          <= 1'b0;
      o_Done          <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (i_Start) begin
            last_r         <= i_Block_Count - index_width'(1);
            o_Row_Index    <= {index_width{1'b0}};
            o_Column_Index <= {index_width{1'b0}};
            o_Busy         <= 1'b1;
            state_r        <= (i_Block_Count == {index_width{1'b0}}) ? S_DONE : S_SELECT;
          end
        end
        S_SELECT: begin
          if (pick_valid_s) begin
            o_Indexes_Ready <= grant_s;
            state_r         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (offer_ack_s) begin
            o_Indexes_Ready <= {NUM_CU{1'b0}};
            // The final pair leaves the bus at (M-1, M-1) so row never exceeds M-1.
            if (last_pair_s) begin
              state_r <= S_DRAIN;
            end else begin
              state_r <= S_SELECT;
              if (last_col_s) begin
                o_Column_Index <= {index_width{1'b0}};
                o_Row_Index    <= o_Row_Index + index_width'(1);
              end else begin
                o_Column_Index <= o_Column_Index + index_width'(1);
              end
            end
          end
        end
        S_DRAIN: begin
          if (busy_r == {NUM_CU{1'b0}}) begin
            state_r <= S_DONE;
          end
        end
        S_DONE: begin
          o_Done  <= 1'b1;
          o_Busy  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          state_r         <= S_IDLE;
          o_Indexes_Ready <= {NUM_CU{1'b0}};
          o_Busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_dispatcher.sv
// Self-checking bench for block_dispatcher: directed scenarios plus randomized jobs
// scored against a row-major / lowest-idle-CU reference model.
module tb_block_dispatcher;

  localparam int NC = 4;
  localparam int IW = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [IW-1:0] bc;
  logic [NC-1:0] recv;
  logic [NC-1:0] res;
  logic [IW-1:0] row;
  logic [IW-1:0] col;
  logic [NC-1:0] rdy;
  logic          busy;
  logic          done;

  int checks;
  int failures;

  block_dispatcher #(
    .NUM_CU      (NC),
    .index_width (IW)
  ) dut (
    .i_Clock            (clk),
    .i_Reset_n          (rst_n),
    .i_Start            (start),
    .i_Block_Count      (bc),
    .i_Indexes_Received (recv),
    .i_Result_Ready     (res),
    .o_Row_Index        (row),
    .o_Column_Index     (col),
    .o_Indexes_Ready    (rdy),
    .o_Busy             (busy),
    .o_Done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    start = 1'b0;
    bc    = 8'd0;
    recv  = 4'b0000;
    res   = 4'b0000;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Reference rule: the lowest-numbered CU that is not busy, or none.
  function automatic logic [NC-1:0] lowest_idle(input logic [NC-1:0] m);
    for (int i = 0; i < NC; i++) begin
      if (!m[i]) return 4'b0001 << i;
    end
    return 4'b0000;
  endfunction

  task automatic test_reset();
    do_reset();
    checks++;
    if ({row, col, rdy, busy, done} !== 22'd0) begin
      failures++;
      $display("FAIL reset_values: got row=%0d col=%0d rdy=%b busy=%b done=%b, want all 0", row, col, rdy, busy, done);
    end
    start = 1'b1;
    bc    = 8'd2;
    tick();
    start = 1'b0;
    checks++;
    if (rdy !== 4'b0000 || busy !== 1'b1) begin
      failures++;
      $display("FAIL start_latency: got rdy=%b busy=%b, want rdy=0000 busy=1", rdy, busy);
    end
    tick();
    checks++;
    if (rdy !== 4'b0001 || row !== 8'd0 || col !== 8'd0) begin
      failures++;
      $display("FAIL first_offer: got rdy=%b row=%0d col=%0d, want 0001 (0,0)", rdy, row, col);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({row, col, rdy, busy, done} !== 22'd0) begin
      failures++;
      $display("FAIL async_reset: got row=%0d col=%0d rdy=%b busy=%b done=%b, want all 0", row, col, rdy, busy, done);
    end
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    bc    = 8'd2;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (rdy !== 4'b0001 || row !== 8'd0 || col !== 8'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reissue_after_reset: got rdy=%b row=%0d col=%0d busy=%b, want 0001 (0,0) busy=1", rdy, row, col, busy);
    end
  endtask

  task automatic test_nominal_2x2();
    do_reset();
    start = 1'b1;
    bc    = 8'd2;
    tick();
    start = 1'b0;
    for (int n = 0; n < 4; n++) begin
      for (int w = 0; w < 20 && rdy == 4'b0000; w++) tick();
      checks++;
      if (rdy !== (4'b0001 << n) || row !== 8'(n / 2) || col !== 8'(n % 2)) begin
        failures++;
        $display("FAIL nominal_offer%0d: got rdy=%b row=%0d col=%0d, want %b (%0d,%0d)", n, rdy, row, col, 4'b0001 << n, n / 2, n % 2);
      end
      recv = rdy;
      tick();
      recv = 4'b0000;
    end
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (rdy !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL nominal_drain_hold: got rdy=%b busy=%b done=%b, want 0000 1 0", rdy, busy, done);
      end
      tick();
    end
    res = 4'b1111;
    tick();
    res = 4'b0000;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL nominal_pre_done: got done=%b busy=%b, want 0 1", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL nominal_done: got done=%b busy=%b, want 1 0", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL nominal_done_width: got done=%b, want 0", done);
    end
  endtask

  // Leaves all four CUs busy with pair (1,2) next, used by test_simultaneous.
  task automatic test_back_pressure();
    do_reset();
    start = 1'b1;
    bc    = 8'd3;
    tick();
    start = 1'b0;
    for (int n = 0; n < 4; n++) begin
      for (int w = 0; w < 20 && rdy == 4'b0000; w++) tick();
      recv = rdy;
      tick();
      recv = 4'b0000;
    end
    tick();
    tick();
    checks++;
    if (rdy !== 4'b0000) begin
      failures++;
      $display("FAIL bp_all_busy: got rdy=%b, want 0000", rdy);
    end
    res = 4'b0010;
    tick();
    res = 4'b0000;
    tick();
    for (int w = 0; w < 5; w++) begin
      checks++;
      if (rdy !== 4'b0010 || row !== 8'd1 || col !== 8'd1) begin
        failures++;
        $display("FAIL bp_hold%0d: got rdy=%b row=%0d col=%0d, want 0010 (1,1)", w, rdy, row, col);
      end
      tick();
    end
    recv = 4'b0010;
    tick();
    recv = 4'b0000;
  endtask

  task automatic test_simultaneous();
    tick();
    checks++;
    if (rdy !== 4'b0000) begin
      failures++;
      $display("FAIL sim_all_busy: got rdy=%b, want 0000", rdy);
    end
    res = 4'b0011;
    tick();
    res = 4'b0000;
    tick();
    checks++;
    if (rdy !== 4'b0001 || row !== 8'd1 || col !== 8'd2) begin
      failures++;
      $display("FAIL sim_next_offer: got rdy=%b row=%0d col=%0d, want 0001 (1,2)", rdy, row, col);
    end
  endtask

  task automatic test_zero_size();
    do_reset();
    start = 1'b1;
    bc    = 8'd0;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || rdy !== 4'b0000) begin
      failures++;
      $display("FAIL zero_cycle1: got busy=%b done=%b rdy=%b, want 1 0 0000", busy, done, rdy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || rdy !== 4'b0000) begin
      failures++;
      $display("FAIL zero_done: got busy=%b done=%b rdy=%b, want 0 1 0000", busy, done, rdy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_after: got done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  // One job driven by randomized worker CUs, scored every cycle against the reference rules.
  task automatic run_job(input int m, input bit spur);
    logic [NC-1:0] mdl, pre_mdl, offer, acked, nack, nres, exp_rdy;
    int ack_wait[NC];
    int res_wait[NC];
    int issued, e_edge, k, p, total;
    mdl    = 4'b0000;
    issued = 0;
    e_edge = -1;
    k      = 0;
    total  = m * m;
    for (int i = 0; i < NC; i++) begin
      ack_wait[i] = -1;
      res_wait[i] = 0;
    end
    recv  = 4'b0000;
    res   = 4'b0000;
    start = 1'b1;
    bc    = 8'(m);
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL job_start m=%0d: got busy=%b done=%b, want 1 0", m, busy, done);
    end
    while (k < 3000) begin
      offer = rdy;
      nack  = 4'b0000;
      nres  = 4'b0000;
      for (int i = 0; i < NC; i++) begin
        if (offer[i]) begin
          if (ack_wait[i] < 0) ack_wait[i] = $urandom_range(0, 3);
          if (ack_wait[i] == 0) nack[i] = 1'b1;
          else ack_wait[i]--;
        end else if (spur && e_edge < 0 && $urandom_range(0, 7) == 0) begin
          nack[i] = 1'b1;
        end
        if (res_wait[i] == 1) nres[i] = 1'b1;
        else if (spur && e_edge < 0 && !mdl[i] && !offer[i] && $urandom_range(0, 7) == 0) nres[i] = 1'b1;
        if (res_wait[i] > 0) res_wait[i]--;
      end
      recv  = nack;
      res   = nres;
      start = spur && (e_edge < 0) && ($urandom_range(0, 15) == 0);
      bc    = 8'($urandom_range(0, 9));
      tick();
      k++;
      acked = offer & nack;
      for (int i = 0; i < NC; i++) begin
        if (acked[i]) begin
          res_wait[i] = $urandom_range(1, 6);
          ack_wait[i] = -1;
        end
      end
      if (offer != 4'b0000) exp_rdy = (acked != 4'b0000) ? 4'b0000 : offer;
      else if (issued < total) exp_rdy = lowest_idle(mdl);
      else exp_rdy = 4'b0000;
      if (acked != 4'b0000) issued++;
      pre_mdl = mdl;
      mdl     = (pre_mdl & ~nres) | acked;
      p       = (issued < total) ? issued : total - 1;
      checks++;
      if (rdy !== exp_rdy || row !== 8'(p / m) || col !== 8'(p % m)) begin
        failures++;
        $display("FAIL job_offer m=%0d k=%0d: got rdy=%b row=%0d col=%0d, want rdy=%b row=%0d col=%0d", m, k, rdy, row, col, exp_rdy, p / m, p % m);
      end
      if (e_edge < 0 && issued == total && mdl == 4'b0000) e_edge = k;
      checks++;
      if (done !== (e_edge >= 0 && k == e_edge + 2) || busy !== !(e_edge >= 0 && k >= e_edge + 2)) begin
        failures++;
        $display("FAIL job_status m=%0d k=%0d: got done=%b busy=%b, last block returned at k=%0d", m, k, done, busy, e_edge);
      end
      if (e_edge >= 0 && k == e_edge + 3) break;
    end
    recv  = 4'b0000;
    res   = 4'b0000;
    start = 1'b0;
    checks++;
    if (e_edge < 0 || k != e_edge + 3) begin
      failures++;
      $display("FAIL job_timeout m=%0d: got issued=%0d after %0d cycles, want %0d blocks completed", m, issued, k, total);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    run_job(3, 1'b1);
  endtask

  task automatic test_random_jobs();
    do_reset();
    run_job(1, 1'b0);
    for (int j = 0; j < 6; j++) begin
      run_job($urandom_range(1, 5), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    bc       = 8'd0;
    recv     = 4'b0000;
    res      = 4'b0000;
    test_reset();
    test_nominal_2x2();
    test_back_pressure();
    test_simultaneous();
    test_zero_size();
    test_spurious();
    test_random_jobs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
